// File: rtl/rsa_pkg.sv
// ============================================================================
// rsa_pkg : shared widths, FSM state encoding and coefficient type for RSA blocks
// Revision: 1.0
// ============================================================================
`default_nettype none

package rsa_pkg;

    localparam int BIT = 8;
    localparam int TW  = BIT + 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        CHECK     = 3'd2,
        DIV_START = 3'd3,
        DIV_WAIT  = 3'd4,
        UPDATE    = 3'd5,
        FIX       = 3'd6,
        DONE      = 3'd7
    } state_t;

    typedef logic signed [TW-1:0] coef_t;

endpackage

`default_nettype wire

// File: rtl/rsa_modinv_if.sv
// ============================================================================
// rsa_modinv_if : request/result bundle for the modular-inverse engine
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rsa_modinv_if;
    import rsa_pkg::*;

    logic           start;
    logic [BIT-1:0] E;
    logic [BIT-1:0] PHI;
    logic           busy;
    logic           done;
    logic           valid;
    logic [BIT-1:0] D;

    modport master (output start, E, PHI, input busy, done, valid, D);
    modport slave  (input start, E, PHI, output busy, done, valid, D);

endinterface

`default_nettype wire

// File: rtl/rsa_modinv_seq_divider.sv
// ============================================================================
// seq_divider : WIDTH-bit restoring divider, WIDTH+1 cycles from start to done
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_divider
    import rsa_pkg::*;
#(
    parameter int WIDTH = BIT
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] quotient,
    output logic      [WIDTH-1:0] remainder,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    // Partial remainder never reaches 2*divisor, so WIDTH+1 bits hold the shifted value.
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_div});
        w_diff  = w_shift - {1'b0, r_div};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_busy) begin
                r_rem  <= '0;
                r_quo  <= dividend;
                r_div  <= divisor;
                r_cnt  <= CW'(WIDTH);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_ge};
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: rtl/rsa_modinv.sv
// ============================================================================
// rsa_modinv : D = E^-1 mod PHI via iterative extended Euclid
// Revision: 1.0
// ============================================================================
`default_nettype none

module rsa_modinv
    import rsa_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    rsa_modinv_if.slave bus
);

    state_t         r_state, w_state;
    logic [BIT-1:0] r_r0, w_r0;
    logic [BIT-1:0] r_r1, w_r1;
    logic [BIT-1:0] r_r2, w_r2;
    logic [BIT-1:0] r_q, w_q;
    logic [BIT-1:0] r_phi, w_phi;
    coef_t          r_t0, w_t0;
    coef_t          r_t1, w_t1;
    logic           r_busy, w_busy;
    logic           r_done, w_done;
    logic           r_valid, w_valid;
    logic [BIT-1:0] r_d, w_d;

    logic                  w_div_start;
    logic [BIT-1:0]        w_div_q;
    logic [BIT-1:0]        w_div_r;
    logic                  w_div_busy;
    logic                  w_div_done;
    logic signed [2*BIT+1:0] w_prod;
    coef_t                 w_t2;
    coef_t                 w_fix;

    seq_divider #(
        .WIDTH (BIT)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_div_start),
        .dividend  (r_r0),
        .divisor   (r_r1),
        .quotient  (w_div_q),
        .remainder (w_div_r),
        .busy      (w_div_busy),
        .done      (w_div_done)
    );

    // Bezout magnitudes stay below PHI, so keeping the low TW product bits is exact.
    always_comb begin
        w_prod = $signed({{(BIT+2){1'b0}}, r_q}) * $signed({{BIT{r_t1[TW-1]}}, r_t1});
        w_t2   = r_t0 - $signed(w_prod[TW-1:0]);
        w_fix  = r_t0 + $signed({{(TW-BIT){1'b0}}, r_phi});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_r0    <= '0;
            r_r1    <= '0;
            r_r2    <= '0;
            r_q     <= '0;
            r_phi   <= '0;
            r_t0    <= '0;
            r_t1    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_state;
            r_r0    <= w_r0;
            r_r1    <= w_r1;
            r_r2    <= w_r2;
            r_q     <= w_q;
            r_phi   <= w_phi;
            r_t0    <= w_t0;
            r_t1    <= w_t1;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_valid <= w_valid;
            r_d     <= w_d;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_r0        = r_r0;
        w_r1        = r_r1;
        w_r2        = r_r2;
        w_q         = r_q;
        w_phi       = r_phi;
        w_t0        = r_t0;
        w_t1        = r_t1;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_valid     = r_valid;
        w_d         = r_d;
        w_div_start = 1'b0;

        case (r_state)
            IDLE: begin
                // Operands are captured on the accepting edge so later input changes are harmless.
                if (bus.start) begin
                    w_r0    = bus.PHI;
                    w_r1    = bus.E;
                    w_phi   = bus.PHI;
                    w_t0    = '0;
                    w_t1    = coef_t'(1);
                    w_busy  = 1'b1;
                    w_valid = 1'b0;
                    w_d     = '0;
                    w_state = LOAD;
                end
            end
            LOAD: begin
                w_busy  = 1'b1;
                w_state = (r_phi < BIT'(2)) ? FIX : CHECK;
            end
            CHECK: begin
                w_state = (r_r1 == '0) ? FIX : DIV_START;
            end
            DIV_START: begin
                if (!w_div_busy) begin
                    w_div_start = 1'b1;
                    w_state     = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (w_div_done) begin
                    w_q     = w_div_q;
                    w_r2    = w_div_r;
                    w_state = UPDATE;
                end
            end
            UPDATE: begin
                w_r0    = r_r1;
                w_r1    = r_r2;
                w_t0    = r_t1;
                w_t1    = w_t2;
                w_state = CHECK;
            end
            FIX: begin
                if ((r_r0 == BIT'(1)) && (r_phi >= BIT'(2))) begin
                    w_d     = r_t0[TW-1] ? w_fix[BIT-1:0] : r_t0[BIT-1:0];
                    w_valid = 1'b1;
                end else begin
                    w_d     = '0;
                    w_valid = 1'b0;
                end
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = DONE;
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.valid = r_valid;
    assign bus.D     = r_d;

endmodule

`default_nettype wire

// File: doc/rsa_modinv.md
Name: rsa_modinv

Overview:
- Computes the RSA private exponent D = E^-1 mod PHI with the extended Euclidean algorithm.
- It is the key-side counterpart of the modular-exponentiation encrypt engine: the D it produces feeds the exponent input of the same engine for decryption.
- 8-bit datapath; an iterative FSM drives one sequential restoring divider.
- Reports whether the inverse exists, i.e. whether gcd(E,PHI)==1.

Parameters:
- BIT, 8, operand width for E, PHI and D.
- TW, BIT+2, signed width of the Bezout coefficients t0/t1/t2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request, sampled only in IDLE; one-cycle pulse or level both accepted.
- E  in  BIT  public exponent, captured on accepted start.
- PHI  in  BIT  modulus phi(n), captured on accepted start.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse when D/valid are updated.
- valid  out  1  1 = inverse exists; held until the next accepted start.
- D  out  BIT  inverse in the range [1, PHI-1]; 0 when valid=0; held until the next start.

Behaviour:
- Reset, asynchronous: state=IDLE; busy=0, done=0, valid=0, D=0. Internal registers are cleared and the divider is reset.
- Reset mid-operation aborts the computation immediately. No done pulse is issued and no partial result is produced.
- Registers: r0, r1 (BIT unsigned); t0, t1 (TW signed); q (BIT); phi_reg (BIT).
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: r0=PHI, r1=E, t0=0, t1=1, phi_reg=PHI; busy<=1; valid<=0. If PHI<2 -> FIX, which reports invalid; else -> CHECK.
  - CHECK: r1==0 -> FIX; else -> DIV_START.
  - DIV_START: divider start pulse with dividend r0 and divisor r1 -> DIV_WAIT.
  - DIV_WAIT: wait for the divider's done pulse; latch q -> UPDATE. The remainder is also latched as r2.
  - UPDATE: r0<=r1, r1<=r2, t0<=t1, t1<=t0-q*t1 -> CHECK.
    - The product is formed at 2*BIT+2 bits and truncated to TW. |t| never exceeds PHI, so truncation is lossless.
  - FIX:
    - If r0==1 and PHI>=2: D = t0<0 ? t0+phi_reg : t0, truncated to BIT; valid<=1.
    - Otherwise D<=0 and valid<=0.
    - -> DONE.
  - DONE: done=1 for this one cycle, busy<=0 -> IDLE.
- E>=PHI needs no special handling: the first iteration yields q>=1 or swaps the operands.
- E==0: CHECK immediately goes to FIX with r0=PHI>=2, so valid=0.
- start asserted while busy is ignored. A start held high in DONE is not re-sampled until IDLE. A held level restarts one cycle after done.
- Divider latency: exactly BIT+1 cycles from its start to its done (BIT shift/subtract cycles plus 1 load).
- Iteration cost: DIV_START + (BIT+1) + UPDATE + CHECK = BIT+4 cycles. At most 12 iterations for BIT=8.
- Worst case from start accepted to done is ≤ 12*(BIT+4)+4 = 148 cycles. A bench timeout is 200 cycles.
- Outputs are registered and have no combinational paths from inputs.

Decomposition:
- Shared package rsa_pkg, containing:
  - constants BIT and TW;
  - the FSM state enum (IDLE, LOAD, CHECK, DIV_START, DIV_WAIT, UPDATE, FIX, DONE);
  - a signed coefficient typedef of width TW.
- One sub-module, seq_divider: a BIT-wide restoring divider.
  - Ports: clk, rst_n, start, dividend, divisor, quotient, remainder, busy, done.
  - Fixed BIT+1 cycle latency.
  - A divisor of 0 is never issued by rsa_modinv.
  - Reusable by other RSA blocks.

Test Plan:
- E=7, PHI=40, start pulse -> done within 200 cycles; valid=1, D=23; busy falls in the same cycle done rises.
- E=254, PHI=255 -> valid=1, D=254. E=1, PHI=255 -> valid=1, D=1. Both exercise the negative-t0 correction path and the trivial path.
- E=43, PHI=40 (E>PHI) -> valid=1, D=27. E=3, PHI=20 -> valid=1, D=7.
- Non-invertible or degenerate inputs: E=6, PHI=20 -> valid=0, D=0. E=0, PHI=20 -> valid=0, D=0. E=5, PHI=1 -> valid=0, D=0 within 5 cycles.
- Handshake:
  - a second start pulse mid-computation with E=3, PHI=20 is ignored; the result is still D=23 for the 7/40 job;
  - start held high -> a new computation begins one cycle after done, and valid/D hold until then.
- rst_n low for 1 cycle in DIV_WAIT -> busy, done, valid and D are 0 asynchronously.
  - A fresh start with E=7, PHI=40 then completes normally with D=23.
